st3_muldiv_seq: RTL
===================

Name: st3_muldiv_seq

Overview:
Multi-cycle sequencer for the stage-3 signed multiply (aluFunct 4'b0100) and divide (4'b0101) operations, so these no longer sit in a single combinational ALU path. It accepts an operation from the EX stage, stalls the pipeline while it iterates, then presents a registered {hi/remainder, lo/quotient} pair. The pair is written back as aluOut2/aluOut1, with R15 receiving aluOut2. It also raises ALU_exception for divide-by-zero and the divide overflow case.

Parameters:
WIDTH, 16, operand/result half width; iteration count equals WIDTH
FUNCT_MUL, 4'b0100, aluFunct code for signed multiply
FUNCT_DIV, 4'b0101, aluFunct code for signed divide

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  EX stage presents a valid instruction this cycle
aluFunct  input  4  operation code; only FUNCT_MUL/FUNCT_DIV act
reg1  input  WIDTH  signed operand A (multiplicand / dividend)
reg2  input  WIDTH  signed operand B (multiplier / divisor)
flush  input  1  synchronous cancel of any in-flight operation
stall  output  1  combinational; freeze upstream pipeline
busy  output  1  registered; high in MUL or DIV state
done  output  1  registered; one-cycle pulse, results valid
aluOut1  output  WIDTH  product low half / quotient
aluOut2  output  WIDTH  product high half / remainder
ALU_exception  output  1  registered; valid only with done

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset (rst=0, async) -> IDLE. Reset also clears done, busy, ALU_exception, aluOut1, aluOut2 and the iteration counter to 0.
- Accept: in IDLE or DONE, start=1 with aluFunct in {FUNCT_MUL, FUNCT_DIV} is sampled at the clock edge.
  - The edge latches |reg1|, |reg2|, the result sign, the dividend sign and the op.
  - The counter loads WIDTH-1 and the state moves to MUL or DIV.
  - Any other aluFunct, or start=0, leaves the state at IDLE.
- Back-to-back: accept from DONE is legal. done still pulses for the completing operation in that cycle.
- MUL: unsigned shift-add on magnitudes, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- DIV: restoring division on magnitudes, one quotient bit per cycle.
- Counter decrements each cycle. At count 0 the next state is DONE.
- Latency: done=1 exactly WIDTH+1 cycles after the accepting edge (17 for default). busy=1 for WIDTH cycles.
- DONE entry applies sign correction and registers the outputs:
  - MUL: {aluOut2, aluOut1} is the two's-complement 2*WIDTH-bit product, negated when the operand signs differ.
  - DIV: quotient truncates toward zero. The remainder takes the dividend's sign.
  - aluOut1/aluOut2 hold their values until the next DONE entry or reset.
- DONE lasts one cycle, then returns to IDLE unless a new accept occurs.
- Divide by zero (reg2=0 at accept): no iteration. The state goes directly to DONE on the next edge, so done arrives 1 cycle after accept. ALU_exception=1, aluOut1 is unchanged, aluOut2 is unchanged.
- Divide overflow (reg1=-2^(WIDTH-1), reg2=-1): the full iteration runs. aluOut1=0x8000 (wrapped), aluOut2=0, ALU_exception=1.
- ALU_exception is 0 for every multiply. It clears on any cycle where done=0.
- stall = (state in {MUL, DIV}) OR (accept condition true this cycle).
  - stall is 0 in DONE unless a new accept occurs, so the pipeline captures the results on the done cycle.
- flush=1: the next edge forces IDLE. There is no done pulse and outputs are unchanged. flush has priority over start; a start in the same cycle is dropped. flush in IDLE has no effect.
- Operand changes on reg1/reg2 after the accepting edge are ignored.
- Reset mid-operation aborts immediately: outputs go to 0 and no done pulse is produced.

Test Plan:
- Multiply: start, FUNCT_MUL, reg1=7, reg2=-3 -> done at accept+17; aluOut1=0xFFEB, aluOut2=0xFFFF, ALU_exception=0; stall high from the accept cycle through accept+16, low on done.
- Multiply: reg1=0x8000, reg2=0x8000 -> aluOut2=0x4000, aluOut1=0x0000; 0x7FFF*0x7FFF -> aluOut2=0x3FFF, aluOut1=0x0001.
- Divide: reg1=-7, reg2=2 -> aluOut1=0xFFFD, aluOut2=0xFFFF. Then 100/7 accepted on the done cycle (back-to-back) -> done 17 cycles later, aluOut1=14, aluOut2=2.
- Exceptions: 5/0 -> done at accept+1, ALU_exception=1, outputs equal the prior values. 0x8000/0xFFFF -> aluOut1=0x8000, aluOut2=0, ALU_exception=1.
- Flush/reset:
  - flush at accept+5 -> IDLE at next edge, no done, stall low.
  - flush+start in the same cycle -> no accept.
  - rst=0 asynchronously mid-DIV -> all outputs 0 immediately.
  - aluFunct=4'b0000 with start -> no stall, state stays IDLE.

Source files
------------

// File: rtl/st3_muldiv_seq_if.sv
// rtl/st3_muldiv_seq_if.sv - EX-stage to multiply/divide sequencer handshake bundle
interface st3_muldiv_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       aluFunct;
    logic [WIDTH-1:0] reg1;
    logic [WIDTH-1:0] reg2;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] aluOut1;
    logic [WIDTH-1:0] aluOut2;
    logic             ALU_exception;

    modport master (
        output start, aluFunct, reg1, reg2, flush,
        input  stall, busy, done, aluOut1, aluOut2, ALU_exception
    );

    modport slave (
        input  start, aluFunct, reg1, reg2, flush,
        output stall, busy, done, aluOut1, aluOut2, ALU_exception
    );
endinterface

// File: rtl/st3_muldiv_seq.sv
// rtl/st3_muldiv_seq.sv - multi-cycle signed multiply/divide sequencer for stage 3
// Iterates on operand magnitudes, applies sign correction when entering DONE.
module st3_muldiv_seq #(
    parameter int         WIDTH     = 16,
    parameter logic [3:0] FUNCT_MUL = 4'b0100,
    parameter logic [3:0] FUNCT_DIV = 4'b0101
) (
    input  logic             clk,
    input  logic             rst,
    st3_muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               res_neg;
    logic               dvd_neg;

    logic               is_mul;
    logic               is_div;
    logic               accept;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_mul = (bus.aluFunct == FUNCT_MUL);
    assign is_div = (bus.aluFunct == FUNCT_DIV);
    assign accept = ((state == S_IDLE) || (state == S_DONE)) && bus.start
                    && (is_mul || is_div) && !bus.flush;
    assign bus.stall = (state == S_MUL) || (state == S_DIV) || accept;

    assign mag_a = bus.reg1[WIDTH-1] ? -bus.reg1 : bus.reg1;
    assign mag_b = bus.reg2[WIDTH-1] ? -bus.reg2 : bus.reg2;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    // Divide: acc = {partial remainder, remaining dividend / growing quotient}.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_rem   = div_shift[WIDTH-1:0] - opnd;

    always_comb begin
        step = '0;
        if (state == S_DIV) begin
            step = {(div_ge ? div_rem : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        end else begin
            step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign prod_fix = res_neg ? -step : step;
    assign quo_fix  = res_neg ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    assign rem_fix  = dvd_neg ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            acc               <= '0;
            opnd              <= '0;
            res_neg           <= 1'b0;
            dvd_neg           <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.ALU_exception <= 1'b0;
            bus.aluOut1       <= '0;
            bus.aluOut2       <= '0;
        end else begin
            bus.done          <= 1'b0;
            bus.ALU_exception <= 1'b0;
            if (bus.flush && (state != S_IDLE)) begin
                state    <= S_IDLE;
                bus.busy <= 1'b0;
            end else if (accept) begin
                cnt     <= CNT_LOAD;
                res_neg <= bus.reg1[WIDTH-1] ^ bus.reg2[WIDTH-1];
                dvd_neg <= bus.reg1[WIDTH-1];
                opnd    <= is_mul ? mag_a : mag_b;
                acc     <= {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
                if (is_div && (bus.reg2 == '0)) begin
                    // Divide by zero skips iteration; result registers keep their old value.
                    state             <= S_DONE;
                    bus.busy          <= 1'b0;
                    bus.done          <= 1'b1;
                    bus.ALU_exception <= 1'b1;
                end else begin
                    state    <= is_mul ? S_MUL : S_DIV;
                    bus.busy <= 1'b1;
                end
            end else begin
                case (state)
                    S_MUL, S_DIV: begin
                        acc <= step;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            state    <= S_DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            if (state == S_MUL) begin
                                {bus.aluOut2, bus.aluOut1} <= prod_fix;
                            end else begin
                                bus.aluOut1 <= quo_fix;
                                bus.aluOut2 <= rem_fix;
                                // Only -2^(W-1) / -1 yields a non-negative quotient with the top bit set.
                                bus.ALU_exception <= !res_neg && quo_fix[WIDTH-1];
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
